traffic_gen_engine: RTL and testbench



---
 rtl/traffic_gen_engine.sv | 174 +++++++++++++++++
 tb/tb_traffic_gen_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen_engine.sv
// Traffic generator: forwards beats from the r stream to a one-entry w output register,
// gating acceptance with alternating request/idle phases and counting completed w beats.
module traffic_gen_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                clear_i,
  input  logic                ctrl_clear_i,
  input  logic                ctrl_enable_i,
  input  logic                ctrl_start_i,
  input  logic [CNT_W-1:0]    ctrl_n_total_reqs_i,
  input  logic [CNT_W-1:0]    ctrl_t_ck_reqs_i,
  input  logic [CNT_W-1:0]    ctrl_t_ck_idle_i,
  input  logic [CNT_W-1:0]    ctrl_cnt_limit_i,
  output logic                flags_ready_o,
  output logic [CNT_W-1:0]    flags_cnt_w_reqs_o,
  input  logic                r_reqs_valid_i,
  output logic                r_reqs_ready_o,
  input  logic [DATA_W-1:0]   r_reqs_data_i,
  output logic                w_reqs_valid_o,
  input  logic                w_reqs_ready_i,
  output logic [DATA_W-1:0]   w_reqs_data_o,
  output logic [DATA_W/8-1:0] w_reqs_strb_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_total_q, n_total_d;
  logic [CNT_W-1:0]    t_reqs_q, t_reqs_d;
  logic [CNT_W-1:0]    t_idle_q, t_idle_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drain_entry_q, drain_entry_d;
  logic                w_valid_q, w_valid_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;

  logic             r_ready, r_hs, w_hs;
  logic [CNT_W-1:0] req_last;
  logic             unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign w_hs     = w_valid_q & w_reqs_ready_i;
  assign r_ready  = (state_q == S_REQ) && ctrl_enable_i && (acc_q < n_total_q)
                    && (!w_valid_q || w_reqs_ready_i);
  assign r_hs     = r_ready & r_reqs_valid_i;
  // A zero-length request phase still lasts one cycle.
  assign req_last = (t_reqs_q == '0) ? '0 : t_reqs_q - CNT_W'(1);

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    n_total_d     = n_total_q;
    t_reqs_d      = t_reqs_q;
    t_idle_d      = t_idle_q;
    acc_d         = acc_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    drain_entry_d = drain_entry_q;
    w_valid_d     = w_valid_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;

    if (r_hs) begin
      w_valid_d = 1'b1;
      w_data_d  = r_reqs_data_i;
      w_strb_d  = '1;
    end else if (w_hs) begin
      w_valid_d = 1'b0;
    end

    // Completed beats count even while the engine is frozen.
    if (w_hs && (cnt_q < ctrl_cnt_limit_i)) cnt_d = cnt_q + CNT_W'(1);

    if (ctrl_enable_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (ctrl_start_i) begin
            n_total_d = ctrl_n_total_reqs_i;
            t_reqs_d  = ctrl_t_ck_reqs_i;
            t_idle_d  = ctrl_t_ck_idle_i;
            acc_d     = '0;
            phase_d   = '0;
            if (ctrl_n_total_reqs_i == '0) begin
              state_d       = S_DRAIN;
              drain_entry_d = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (r_hs) acc_d = acc_q + CNT_W'(1);
          if (r_hs && (acc_q + CNT_W'(1) == n_total_q)) begin
            state_d       = S_DRAIN;
            drain_entry_d = 1'b1;
          end else if (phase_q == req_last) begin
            phase_d = '0;
            if (t_idle_q != '0) state_d = S_GAP;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (phase_q == t_idle_q - CNT_W'(1)) begin
            phase_d = '0;
            state_d = S_REQ;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // The entry cycle never exits, so DRAIN always lasts at least two cycles.
          if (drain_entry_q)   drain_entry_d = 1'b0;
          else if (!w_valid_q) state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (clear_i || ctrl_clear_i) begin
      state_d       = S_IDLE;
      acc_d         = '0;
      phase_d       = '0;
      cnt_d         = '0;
      drain_entry_d = 1'b0;
      w_valid_d     = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the output data/strobe register is reset too, so the bus reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      n_total_q     <= '0;
      t_reqs_q      <= '0;
      t_idle_q      <= '0;
      acc_q         <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      drain_entry_q <= 1'b0;
      w_valid_q     <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      state_q       <= state_d;
      n_total_q     <= n_total_d;
      t_reqs_q      <= t_reqs_d;
      t_idle_q      <= t_idle_d;
      acc_q         <= acc_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      drain_entry_q <= drain_entry_d;
      w_valid_q     <= w_valid_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
    end
  end

  assign flags_ready_o      = (state_q == S_IDLE);
  assign flags_cnt_w_reqs_o = cnt_q;
  assign r_reqs_ready_o     = r_ready;
  assign w_reqs_valid_o     = w_valid_q;
  assign w_reqs_data_o      = w_data_q;
  assign w_reqs_strb_o      = w_strb_q;

endmodule

// File: tb/tb_traffic_gen_engine.sv
// Randomized bench for traffic_gen_engine: a phase-window/queue model predicts the
// r acceptance pattern, the w beat stream, the write counter and the return to idle.
module tb_traffic_gen_engine;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                test_mode_i = 1'b0;
  logic                clear_i = 1'b0;
  logic                ctrl_clear_i = 1'b0;
  logic                ctrl_enable_i = 1'b1;
  logic                ctrl_start_i = 1'b0;
  logic [CNT_W-1:0]    ctrl_n_total_reqs_i = '0;
  logic [CNT_W-1:0]    ctrl_t_ck_reqs_i = '0;
  logic [CNT_W-1:0]    ctrl_t_ck_idle_i = '0;
  logic [CNT_W-1:0]    ctrl_cnt_limit_i = '0;
  logic                flags_ready_o;
  logic [CNT_W-1:0]    flags_cnt_w_reqs_o;
  logic                r_reqs_valid_i = 1'b0;
  logic                r_reqs_ready_o;
  logic [DATA_W-1:0]   r_reqs_data_i = '0;
  logic                w_reqs_valid_o;
  logic                w_reqs_ready_i = 1'b0;
  logic [DATA_W-1:0]   w_reqs_data_o;
  logic [DATA_W/8-1:0] w_reqs_strb_o;

  traffic_gen_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
    .clear_i(clear_i), .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
    .ctrl_start_i(ctrl_start_i), .ctrl_n_total_reqs_i(ctrl_n_total_reqs_i),
    .ctrl_t_ck_reqs_i(ctrl_t_ck_reqs_i), .ctrl_t_ck_idle_i(ctrl_t_ck_idle_i),
    .ctrl_cnt_limit_i(ctrl_cnt_limit_i), .flags_ready_o(flags_ready_o),
    .flags_cnt_w_reqs_o(flags_cnt_w_reqs_o), .r_reqs_valid_i(r_reqs_valid_i),
    .r_reqs_ready_o(r_reqs_ready_o), .r_reqs_data_i(r_reqs_data_i),
    .w_reqs_valid_o(w_reqs_valid_o), .w_reqs_ready_i(w_reqs_ready_i),
    .w_reqs_data_o(w_reqs_data_o), .w_reqs_strb_o(w_reqs_strb_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int cnt_limit = 1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_cnt = 0;
  endtask

  // One run: cycle k counts from 1 after the start edge. With enable held high, cycle k
  // is inside a request window when (k-1) mod (R+idle) < R, R = max(t_reqs,1).
  task automatic run(input int n, input int tr, input int ti, input int rv_pct, input int wr_pct);
    logic [DATA_W-1:0] q[$];
    int k, acc, r_len, period, e, idle_at;
    logic rv, wr, exp_rr, hs_r, hs_w;
    logic [DATA_W-1:0] rd;
    ctrl_enable_i       = 1'b1;
    ctrl_cnt_limit_i    = CNT_W'(cnt_limit);
    ctrl_n_total_reqs_i = CNT_W'(n);
    ctrl_t_ck_reqs_i    = CNT_W'(tr);
    ctrl_t_ck_idle_i    = CNT_W'(ti);
    ctrl_start_i        = 1'b1;
    @(negedge clk_i);
    check("ready_before_start", flags_ready_o, 1'b1);
    @(posedge clk_i); #1;
    ctrl_start_i = 1'b0;
    r_len  = (tr == 0) ? 1 : tr;
    period = r_len + ti;
    k = 1; acc = 0;
    while (!(acc == n && q.size() == 0) && k < 4000) begin
      rv = ($urandom_range(99) < rv_pct);
      wr = ($urandom_range(99) < wr_pct);
      rd = $urandom;
      r_reqs_valid_i = rv; w_reqs_ready_i = wr; r_reqs_data_i = rd;
      @(negedge clk_i);
      exp_rr = (((k - 1) % period) < r_len) && (acc < n) && (q.size() == 0 || wr);
      check("r_ready", r_reqs_ready_o, exp_rr);
      check("w_valid", w_reqs_valid_o, q.size() != 0);
      check("busy", flags_ready_o, 1'b0);
      check("cnt", flags_cnt_w_reqs_o, CNT_W'(exp_cnt));
      if (q.size() != 0) begin
        check("w_data", w_reqs_data_o, q[0]);
        check("w_strb", w_reqs_strb_o, {(DATA_W/8){1'b1}});
      end
      hs_w = (q.size() != 0) && wr;
      hs_r = exp_rr && rv;
      if (hs_w) begin
        void'(q.pop_front());
        if (exp_cnt < cnt_limit) exp_cnt++;
      end
      if (hs_r) begin
        q.push_back(rd);
        acc++;
      end
      @(posedge clk_i); #1;
      k++;
    end
    if (k >= 4000) check("run_timeout", 1'b1, 1'b0);
    // Last w beat drains at cycle e-1; DRAIN spans >= 2 cycles, then IDLE.
    e = k;
    idle_at = ((e > 2) ? e : 2) + 1;
    while (k <= idle_at) begin
      r_reqs_valid_i = 1'b1; w_reqs_ready_i = 1'b1;
      @(negedge clk_i);
      check("drain_ready_flag", flags_ready_o, k == idle_at);
      check("drain_r_ready", r_reqs_ready_o, 1'b0);
      check("drain_w_valid", w_reqs_valid_o, 1'b0);
      check("drain_cnt", flags_cnt_w_reqs_o, CNT_W'(exp_cnt));
      @(posedge clk_i); #1;
      k++;
    end
    r_reqs_valid_i = 1'b0; w_reqs_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    #1;
    check("rst_ready", flags_ready_o, 1'b1);
    check("rst_w_valid", w_reqs_valid_o, 1'b0);
    check("rst_w_data", w_reqs_data_o, '0);
    check("rst_w_strb", w_reqs_strb_o, '0);
    check("rst_r_ready", r_reqs_ready_o, 1'b0);
    check("rst_cnt", flags_cnt_w_reqs_o, '0);
    #12 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run(4, 10, 0, 100, 100);   // back-to-back, single long window
    run(4, 2, 3, 100, 100);    // 2 beats, 3 idle, 2 beats
    run(6, 3, 1, 100, 25);     // frequent output back-pressure
    run(0, 5, 5, 100, 100);    // empty run: DRAIN then IDLE
    do_clear();
    cnt_limit = 3;
    run(5, 4, 2, 100, 100);    // counter saturates at 3
    cnt_limit = 1000;
    for (int i = 0; i < 12; i++)
      run($urandom_range(12), $urandom_range(5), $urandom_range(4),
          $urandom_range(100, 30), $urandom_range(100, 30));

    // Engine clear with a beat pending; counter is nonzero here.
    ctrl_n_total_reqs_i = 8; ctrl_t_ck_reqs_i = 10; ctrl_t_ck_idle_i = 0;
    ctrl_start_i = 1'b1; r_reqs_valid_i = 1'b1; w_reqs_ready_i = 1'b0;
    @(posedge clk_i); #1;
    ctrl_start_i = 1'b0;
    @(posedge clk_i); #1;
    ctrl_clear_i = 1'b1;
    @(negedge clk_i);
    check("clr_pending", w_reqs_valid_o, 1'b1);
    check("clr_cnt_before", flags_cnt_w_reqs_o != 0, 1'b1);
    @(posedge clk_i); #1;
    ctrl_clear_i = 1'b0; r_reqs_valid_i = 1'b0;
    exp_cnt = 0;
    @(negedge clk_i);
    check("clr_ready", flags_ready_o, 1'b1);
    check("clr_w_valid", w_reqs_valid_o, 1'b0);
    check("clr_cnt", flags_cnt_w_reqs_o, '0);
    @(posedge clk_i); #1;

    // Freeze: pending beat still completes and counts, state stays busy.
    ctrl_n_total_reqs_i = 3; r_reqs_data_i = 32'hA5A5_0001;
    ctrl_start_i = 1'b1; r_reqs_valid_i = 1'b1; w_reqs_ready_i = 1'b0;
    @(posedge clk_i); #1;
    ctrl_start_i = 1'b0;
    @(posedge clk_i); #1;
    ctrl_enable_i = 1'b0;
    @(negedge clk_i);
    check("frz_r_ready", r_reqs_ready_o, 1'b0);
    check("frz_w_valid", w_reqs_valid_o, 1'b1);
    check("frz_w_data", w_reqs_data_o, 32'hA5A5_0001);
    @(posedge clk_i); #1;
    w_reqs_ready_i = 1'b1;
    @(negedge clk_i);
    check("frz_r_ready_wr", r_reqs_ready_o, 1'b0);
    @(posedge clk_i); #1;
    w_reqs_ready_i = 1'b0;
    @(negedge clk_i);
    check("frz_cnt", flags_cnt_w_reqs_o, 1);
    check("frz_w_drop", w_reqs_valid_o, 1'b0);
    check("frz_busy", flags_ready_o, 1'b0);
    @(posedge clk_i); #1;
    ctrl_enable_i = 1'b1;
    do_clear();

    // Asynchronous reset mid-run with a beat pending.
    ctrl_n_total_reqs_i = 8;
    ctrl_start_i = 1'b1; r_reqs_valid_i = 1'b1; w_reqs_ready_i = 1'b1;
    @(posedge clk_i); #1;
    ctrl_start_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    w_reqs_ready_i = 1'b0;
    #2;
    check("pre_rst_w_valid", w_reqs_valid_o, 1'b1);
    check("pre_rst_cnt", flags_cnt_w_reqs_o, 2);
    rst_ni = 1'b0;
    #1;
    check("arst_ready", flags_ready_o, 1'b1);
    check("arst_w_valid", w_reqs_valid_o, 1'b0);
    check("arst_w_data", w_reqs_data_o, '0);
    check("arst_w_strb", w_reqs_strb_o, '0);
    check("arst_r_ready", r_reqs_ready_o, 1'b0);
    check("arst_cnt", flags_cnt_w_reqs_o, '0);
    #10 rst_ni = 1'b1;
    r_reqs_valid_i = 1'b0;
    @(posedge clk_i); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
